// File: rtl/neural_sim_pkg.sv
// Shared types and defaults for the neural sample playback path:
// state encoding, default widths/depth and trigger counter limits.
package neural_sim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned DEF_DATA_W = 12;
    localparam int unsigned DEF_ADDR_W = 13;
    localparam int unsigned DEF_DEPTH  = 5000;
    localparam int unsigned DEF_DIV_W  = 8;

    localparam int unsigned             TRGG_CNT_W   = 16;
    localparam logic [TRGG_CNT_W-1:0]   TRGG_CNT_MAX = '1;

    function automatic logic [TRGG_CNT_W-1:0] sat_inc(input logic [TRGG_CNT_W-1:0] v);
        return (v == TRGG_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/playback_tick_gen.sv
// Read-rate divider: counts 0..div while running and pulses tick when the
// count reaches div; holds its count while paused.
module playback_tick_gen
    import neural_sim_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             CLK_ADC,
    input  logic             nRST,
    input  logic             clear,
    input  logic             hold,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    assign tick = !hold && (count == div);

    always_ff @(posedge CLK_ADC or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!hold) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/neural_playback_ctrl.sv
// Playback sequencer for the neural sample memory: paced reads, pause/abort,
// trigger counting. Multi-pass looping is compiled in with PLAYBACK_LOOP_EN.
module neural_playback_ctrl
    import neural_sim_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned DIV_W  = DEF_DIV_W
) (
    input  logic                     CLK_ADC,
    input  logic                     nRST,
    input  logic                     CMD_START,
    input  logic                     CMD_PAUSE,
    input  logic                     CMD_ABORT,
    input  logic [DIV_W-1:0]         CFG_DIV,
    input  logic [7:0]               CFG_LOOPS,
    output logic                     MEM_RD,
    output logic [ADDR_W-1:0]        MEM_ADDR,
    input  logic signed [DATA_W-1:0] MEM_DATA,
    input  logic                     MEM_TRGG,
    output logic signed [DATA_W-1:0] DATA_OUT,
    output logic                     DATA_VALID,
    output logic                     TRGG_OUT,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [TRGG_CNT_W-1:0]    TRGG_CNT,
    output logic [1:0]               STATE
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [DIV_W-1:0]  div_q;
    logic              tick;
    logic              start_ok;
    logic              last_pass;
    logic              final_tick;
    logic              valid_q;

`ifdef PLAYBACK_LOOP_EN
    logic [7:0] loops_left;
    assign last_pass = (loops_left == '0);
`else
    logic [7:0] loops_unused;
    assign loops_unused = CFG_LOOPS;
    assign last_pass    = 1'b1;
`endif

    assign start_ok   = CMD_START && !CMD_ABORT && (state == ST_IDLE || state == ST_DONE);
    assign final_tick = tick && (addr == LAST_ADDR) && last_pass;

    playback_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
        .CLK_ADC (CLK_ADC),
        .nRST    (nRST),
        .clear   (CMD_ABORT || start_ok),
        .hold    (state != ST_RUN),
        .div     (div_q),
        .tick    (tick)
    );

    assign MEM_RD   = tick;
    assign MEM_ADDR = addr;
    assign STATE    = state;

    always_ff @(posedge CLK_ADC or negedge nRST) begin
        if (!nRST) begin
            state <= ST_IDLE;
            addr  <= '0;
            div_q <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
`ifdef PLAYBACK_LOOP_EN
            loops_left <= '0;
`endif
        end else if (CMD_ABORT) begin
            state <= ST_IDLE;
            addr  <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
`ifdef PLAYBACK_LOOP_EN
            loops_left <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (CMD_START) begin
                        state <= ST_RUN;
                        addr  <= '0;
                        div_q <= CFG_DIV;
                        BUSY  <= 1'b1;
                        DONE  <= 1'b0;
`ifdef PLAYBACK_LOOP_EN
                        loops_left <= CFG_LOOPS;
`endif
                    end
                end
                ST_RUN: begin
                    if (final_tick) begin
                        state <= ST_DONE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end else begin
                        if (tick) begin
                            if (addr == LAST_ADDR) begin
                                addr <= '0;
`ifdef PLAYBACK_LOOP_EN
                                loops_left <= loops_left - 1'b1;
`endif
                            end else begin
                                addr <= addr + 1'b1;
                            end
                        end
                        // a pause on a wrap tick still lets the wrap land first
                        if (CMD_PAUSE) state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (CMD_START) state <= ST_RUN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The memory already registers its read data, so the sample is gated by
    // the delayed strobe instead of re-registered, keeping one-cycle latency.
    assign DATA_VALID = valid_q;
    assign DATA_OUT   = valid_q ? MEM_DATA : '0;
    assign TRGG_OUT   = valid_q && MEM_TRGG;

    always_ff @(posedge CLK_ADC or negedge nRST) begin
        if (!nRST) begin
            valid_q  <= 1'b0;
            TRGG_CNT <= '0;
        end else begin
            valid_q <= MEM_RD && !CMD_ABORT;
            if (start_ok) begin
                TRGG_CNT <= '0;
            end else if (TRGG_OUT) begin
                TRGG_CNT <= sat_inc(TRGG_CNT);
            end
        end
    end

endmodule

// File: tb/tb_neural_playback_ctrl.sv
// Self-checking bench for neural_playback_ctrl: random memory contents checked
// against a sample-order model; a second deep instance exercises saturation.
`timescale 1ns/1ps
module tb_neural_playback_ctrl;

    localparam int DATA_W    = 12;
    localparam int ADDR_W    = 13;
    localparam int DEPTH     = 5000;
    localparam int DIV_W     = 8;
    localparam int BIG_DEPTH = 70000;
    localparam int BIG_ADDR  = 17;
`ifdef PLAYBACK_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic                     CLK_ADC = 1'b0;
    logic                     nRST = 1'b0;
    logic                     cmd_start = 1'b0;
    logic                     cmd_pause = 1'b0;
    logic                     cmd_abort = 1'b0;
    logic [DIV_W-1:0]         cfg_div = '0;
    logic [7:0]               cfg_loops = '0;
    logic                     MEM_RD;
    logic [ADDR_W-1:0]        MEM_ADDR;
    logic signed [DATA_W-1:0] MEM_DATA;
    logic                     MEM_TRGG;
    logic signed [DATA_W-1:0] DATA_OUT;
    logic                     DATA_VALID, TRGG_OUT, BUSY, DONE;
    logic [15:0]              TRGG_CNT;
    logic [1:0]               STATE;

    logic                     b_nrst = 1'b0;
    logic                     b_start = 1'b0;
    logic                     b_done;
    logic [15:0]              b_trgg_cnt;
    logic                     b_unused_rd, b_unused_dv, b_unused_tr, b_unused_busy;
    logic [BIG_ADDR-1:0]      b_unused_addr;
    logic signed [DATA_W-1:0] b_unused_data;
    logic [1:0]               b_unused_state;

    logic signed [DATA_W-1:0] mem_data [DEPTH];
    logic                     mem_trg  [DEPTH];

    int total = 0;
    int bad   = 0;

    always #5 CLK_ADC = ~CLK_ADC;

    always @(posedge CLK_ADC) begin
        if (MEM_RD) begin
            MEM_DATA <= mem_data[MEM_ADDR];
            MEM_TRGG <= mem_trg[MEM_ADDR];
        end
    end

    neural_playback_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .CLK_ADC(CLK_ADC), .nRST(nRST), .CMD_START(cmd_start), .CMD_PAUSE(cmd_pause),
        .CMD_ABORT(cmd_abort), .CFG_DIV(cfg_div), .CFG_LOOPS(cfg_loops),
        .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_TRGG(MEM_TRGG),
        .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .TRGG_OUT(TRGG_OUT), .BUSY(BUSY),
        .DONE(DONE), .TRGG_CNT(TRGG_CNT), .STATE(STATE)
    );

    neural_playback_ctrl #(.DATA_W(DATA_W), .ADDR_W(BIG_ADDR), .DEPTH(BIG_DEPTH), .DIV_W(DIV_W)) dut_big (
        .CLK_ADC(CLK_ADC), .nRST(b_nrst), .CMD_START(b_start), .CMD_PAUSE(1'b0),
        .CMD_ABORT(1'b0), .CFG_DIV('0), .CFG_LOOPS('0),
        .MEM_RD(b_unused_rd), .MEM_ADDR(b_unused_addr), .MEM_DATA('0), .MEM_TRGG(1'b1),
        .DATA_OUT(b_unused_data), .DATA_VALID(b_unused_dv), .TRGG_OUT(b_unused_tr),
        .BUSY(b_unused_busy), .DONE(b_done), .TRGG_CNT(b_trgg_cnt), .STATE(b_unused_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One playback run against the model: the stream must be mem[0..DEPTH-1]
    // repeated once per pass, each read div+1 cycles after the previous one.
    task automatic run(input int div, input int loops, input int pause_at, input int abort_at);
        int c, n_rd, n_dv, last_rd, passes, ntrig, pause_cnt, extra, exp_tc;
        bit prev_rd, paused, pause_pending, aborted, finished;
        passes = LOOP_EN ? loops + 1 : 1;
        ntrig = 0;
        foreach (mem_trg[i]) ntrig += int'(mem_trg[i]);
        cfg_div   = DIV_W'(div);
        cfg_loops = 8'(loops);
        cmd_start = 1'b1;
        @(negedge CLK_ADC);
        cmd_start = 1'b0;
        c = 1; n_rd = 0; n_dv = 0; last_rd = 0; pause_cnt = 0; extra = 0; exp_tc = 0;
        prev_rd = 0; paused = 0; pause_pending = 0; aborted = 0; finished = 0;
        check("start_state", STATE, 1);
        check("start_busy", BUSY, 1);
        check("start_cnt_clear", TRGG_CNT, 0);
        while (!finished && c < 40000) begin
            if (aborted) begin
                check("abort_state", STATE, 0);
                check("abort_valid", DATA_VALID, 0);
                check("abort_busy", BUSY, 0);
                check("abort_cnt_hold", TRGG_CNT, exp_tc);
                finished = 1;
            end else begin
                check("valid_latency", DATA_VALID, prev_rd);
                if (DATA_VALID) begin
                    check("data", DATA_OUT, mem_data[n_dv % DEPTH]);
                    check("trgg", TRGG_OUT, mem_trg[n_dv % DEPTH]);
                    exp_tc += int'(mem_trg[n_dv % DEPTH]);
                    n_dv++;
                end else begin
                    check("idle_out", {DATA_OUT, TRGG_OUT}, 0);
                end
                if (pause_pending) begin
                    check("pause_state", STATE, 2);
                    pause_pending = 0;
                end
                if (STATE == 2'd2) begin
                    check("pause_no_rd", MEM_RD, 0);
                    pause_cnt++;
                    extra++;
                    if (pause_cnt == 50) begin
                        cmd_start = 1'b1;
                        cmd_pause = 1'b1;
                    end
                end
                if (MEM_RD) begin
                    check("addr", MEM_ADDR, n_rd % DEPTH);
                    if (n_rd == 0) check("first_rd", c, 1 + div);
                    else check("rd_gap", c - last_rd, div + 1 + extra);
                    extra = 0;
                    last_rd = c;
                    n_rd++;
                    if (int'(MEM_ADDR) == pause_at && !paused) begin
                        cmd_pause = 1'b1;
                        paused = 1;
                        pause_pending = 1;
                    end
                    if (int'(MEM_ADDR) == abort_at) begin
                        cmd_abort = 1'b1;
                        aborted = 1;
                    end
                end
                if (DONE) begin
                    check("done_state", STATE, 3);
                    check("done_busy", BUSY, 0);
                    check("done_reads", n_rd, DEPTH * passes);
                    check("done_samples", n_dv, DEPTH * passes);
                    check("done_after_last", c, last_rd + 1);
                    if (pause_at < 0) check("done_time", c, (div + 1) * DEPTH * passes + 1);
                    @(negedge CLK_ADC);
                    check("trgg_cnt", TRGG_CNT, (ntrig * passes > 65535) ? 65535 : ntrig * passes);
                    check("after_done_valid", DATA_VALID, 0);
                    check("done_held", DONE, 1);
                    finished = 1;
                end
            end
            if (!finished) begin
                prev_rd = MEM_RD;
                @(negedge CLK_ADC);
                cmd_start = 1'b0;
                cmd_pause = 1'b0;
                cmd_abort = 1'b0;
                c++;
            end
        end
        check("run_finished", finished, 1);
    endtask

    initial begin
        int a0, a1, a2;
        foreach (mem_data[i]) begin
            mem_data[i] = DATA_W'($urandom);
            mem_trg[i]  = 1'b0;
        end
        a0 = $urandom_range(0, 40);
        a1 = $urandom_range(1000, 2999);
        a2 = $urandom_range(3000, DEPTH - 1);
        mem_trg[a0] = 1'b1;
        mem_trg[a1] = 1'b1;
        mem_trg[a2] = 1'b1;

        repeat (3) @(negedge CLK_ADC);
        check("rst_state", STATE, 0);
        check("rst_valid", DATA_VALID, 0);
        check("rst_rd", MEM_RD, 0);
        check("rst_addr", MEM_ADDR, 0);
        check("rst_busy_done", {BUSY, DONE}, 0);
        check("rst_cnt", TRGG_CNT, 0);
        check("rst_data", {DATA_OUT, TRGG_OUT}, 0);
        nRST    = 1'b1;
        b_nrst  = 1'b1;
        b_start = 1'b1;
        @(negedge CLK_ADC);
        b_start = 1'b0;

        run(0, 0, -1, -1);
        run(3, 0, -1, $urandom_range(50, 300));
        run(0, 1, -1, -1);
        run(0, 2, -1, -1);
        run(0, 0, 100, -1);
        run($urandom_range(1, 2), 0, $urandom_range(1, DEPTH - 2), -1);

        cfg_div   = '0;
        cfg_loops = '0;
        cmd_start = 1'b1;
        @(negedge CLK_ADC);
        cmd_start = 1'b0;
        repeat ($urandom_range(50, 200)) @(negedge CLK_ADC);
        #2 nRST = 1'b0;
        #1;
        check("midrst_state", STATE, 0);
        check("midrst_valid", DATA_VALID, 0);
        check("midrst_rd", MEM_RD, 0);
        check("midrst_addr", MEM_ADDR, 0);
        check("midrst_cnt", TRGG_CNT, 0);
        check("midrst_busy", BUSY, 0);
        @(negedge CLK_ADC);
        check("midrst_hold_valid", DATA_VALID, 0);
        nRST = 1'b1;

        for (int i = 0; i < 80000 && !b_done; i++) @(negedge CLK_ADC);
        @(negedge CLK_ADC);
        check("sat_done", b_done, 1);
        check("sat_cnt", b_trgg_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
